// File: rtl/frame_sequencer_if.sv
// Frame-mode register bus and frame-sequencer strobe outputs.
// The CPU side drives writes/acks; the sequencer drives strobes, IRQ and step index.
interface frame_sequencer_if;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       irq_ack;
    logic       qtr_clk;
    logic       hlf_clk;
    logic       frame_irq;
    logic [2:0] step_idx;

    modport master (
        output wr_en, wr_data, irq_ack,
        input  qtr_clk, hlf_clk, frame_irq, step_idx
    );

    modport slave (
        input  wr_en, wr_data, irq_ack,
        output qtr_clk, hlf_clk, frame_irq, step_idx
    );
endinterface

// File: rtl/frame_sequencer.sv
// APU frame sequencer: divides apu_clk into steps and issues quarter/half-frame strobes.
// Optional macro FRAME_IRQ_EN adds the 4-step frame interrupt (irq_inhibit, irq_ack).
module frame_sequencer #(
    parameter int STEP_PERIOD = 3728,
    parameter int DIV_W       = 16
) (
    input  logic               apu_clk,
    input  logic               rst,
    frame_sequencer_if.slave   bus
);

    logic [DIV_W-1:0] div_q, div_d;
    logic [2:0]       step_q, step_d;
    logic             qtr_q, qtr_d;
    logic             hlf_q, hlf_d;
    logic             mode_q, mode_d;
    logic             div_last_s;
    logic             unused_s;

    assign div_last_s = (div_q == DIV_W'(STEP_PERIOD - 1));

    // Next-state for divider, step index, mode and strobes; a write overrides step completion.
    always_comb begin
        div_d  = div_q + DIV_W'(1);
        step_d = step_q;
        qtr_d  = 1'b0;
        hlf_d  = 1'b0;
        mode_d = mode_q;
        if (bus.wr_en) begin
            mode_d = bus.wr_data[7];
            div_d  = {DIV_W{1'b0}};
            step_d = 3'd0;
            qtr_d  = bus.wr_data[7];
            hlf_d  = bus.wr_data[7];
        end else if (div_last_s) begin
            div_d = {DIV_W{1'b0}};
            if (mode_q) begin
                qtr_d  = (step_q != 3'd3);
                hlf_d  = (step_q == 3'd1) || (step_q == 3'd4);
                step_d = (step_q >= 3'd4) ? 3'd0 : step_q + 3'd1;
            end else begin
                qtr_d  = 1'b1;
                hlf_d  = (step_q == 3'd1) || (step_q == 3'd3);
                step_d = (step_q >= 3'd3) ? 3'd0 : step_q + 3'd1;
            end
        end else begin
            div_d = div_q + DIV_W'(1);
        end
    end

    // State registers for divider, step index, mode and strobes.
    always_ff @(posedge apu_clk or posedge rst) begin
        if (rst) begin
            div_q  <= {DIV_W{1'b0}};
            step_q <= 3'd0;
            qtr_q  <= 1'b0;
            hlf_q  <= 1'b0;
            mode_q <= 1'b0;
        end else begin
            div_q  <= div_d;
            step_q <= step_d;
            qtr_q  <= qtr_d;
            hlf_q  <= hlf_d;
            mode_q <= mode_d;
        end
    end

    assign bus.qtr_clk  = qtr_q;
    assign bus.hlf_clk  = hlf_q;
    assign bus.step_idx = step_q;

`ifdef FRAME_IRQ_EN
    logic irq_q, irq_d;
    logic inh_q, inh_d;
    logic irq_set_s;

    assign irq_set_s = !bus.wr_en && div_last_s && !mode_q && (step_q == 3'd3) && !inh_q;

    // Frame IRQ: set beats ack; an inhibiting write clears it.
    always_comb begin
        irq_d = irq_q;
        inh_d = inh_q;
        if (bus.wr_en) begin
            inh_d = bus.wr_data[6];
            if (bus.wr_data[6] || bus.irq_ack) begin
                irq_d = 1'b0;
            end else begin
                irq_d = irq_q;
            end
        end else if (irq_set_s) begin
            irq_d = 1'b1;
        end else if (bus.irq_ack) begin
            irq_d = 1'b0;
        end else begin
            irq_d = irq_q;
        end
    end

    // IRQ flag and inhibit registers.
    always_ff @(posedge apu_clk or posedge rst) begin
        if (rst) begin
            irq_q <= 1'b0;
            inh_q <= 1'b0;
        end else begin
            irq_q <= irq_d;
            inh_q <= inh_d;
        end
    end

    assign bus.frame_irq = irq_q;
    assign unused_s      = ^bus.wr_data[5:0];
`else
    assign bus.frame_irq = 1'b0;
    assign unused_s      = ^{bus.wr_data[6:0], bus.irq_ack};
`endif

endmodule

// File: tb/tb_frame_sequencer.sv
// Directed bench for frame_sequencer with a per-cycle reference model built from step pattern tables.
module tb_frame_sequencer;
    localparam int SP = 4;
`ifdef FRAME_IRQ_EN
    localparam bit IRQ_EN = 1'b1;
`else
    localparam bit IRQ_EN = 1'b0;
`endif

    logic apu_clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    frame_sequencer_if bus ();

    frame_sequencer #(.STEP_PERIOD(SP), .DIV_W(16)) dut (
        .apu_clk (apu_clk),
        .rst     (rst),
        .bus     (bus)
    );

    initial apu_clk = 1'b0;
    always #5 apu_clk = ~apu_clk;

    // Strobe tables indexed by the step that just completed.
    bit qtr4 [4] = '{1'b1, 1'b1, 1'b1, 1'b1};
    bit hlf4 [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    bit qtr5 [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    bit hlf5 [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

    int m_cyc = 0, m_step = 0;
    bit m_mode = 0, m_inh = 0, m_irq = 0, m_qtr = 0, m_hlf = 0;

    // Reference model: cycles elapsed in the current step, step number and flags.
    always @(posedge apu_clk or posedge rst) begin
        if (rst) begin
            m_cyc <= 0; m_step <= 0; m_mode <= 0; m_inh <= 0;
            m_irq <= 0; m_qtr <= 0; m_hlf <= 0;
        end else begin
            automatic int  cyc  = m_cyc + 1;
            automatic int  st   = m_step;
            automatic bit  md   = m_mode;
            automatic bit  inh  = m_inh;
            automatic bit  irq  = m_irq;
            automatic bit  q    = 0;
            automatic bit  h    = 0;
            if (IRQ_EN && bus.irq_ack) irq = 0;
            if (bus.wr_en) begin
                md  = bus.wr_data[7];
                inh = IRQ_EN && bus.wr_data[6];
                if (inh) irq = 0;
                cyc = 0; st = 0; q = md; h = md;
            end else if (cyc == SP) begin
                cyc = 0;
                if (md) begin
                    q = qtr5[st]; h = hlf5[st]; st = (st + 1) % 5;
                end else begin
                    q = qtr4[st]; h = hlf4[st];
                    if (st == 3 && !inh && IRQ_EN) irq = 1;
                    st = (st + 1) % 4;
                end
            end
            m_cyc <= cyc; m_step <= st; m_mode <= md; m_inh <= inh;
            m_irq <= irq; m_qtr <= q; m_hlf <= h;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge apu_clk) begin
        chk("model_qtr",  int'(bus.qtr_clk),   int'(m_qtr));
        chk("model_hlf",  int'(bus.hlf_clk),   int'(m_hlf));
        chk("model_irq",  int'(bus.frame_irq), int'(m_irq));
        chk("model_step", int'(bus.step_idx),  m_step);
    end

    task automatic tick(input int n);
        repeat (n) @(negedge apu_clk);
    endtask

    task automatic chk_out(input string name, input int q, input int h, input int s);
        chk({name, "_qtr"},  int'(bus.qtr_clk),  q);
        chk({name, "_hlf"},  int'(bus.hlf_clk),  h);
        chk({name, "_step"}, int'(bus.step_idx), s);
    endtask

    task automatic write(input logic [7:0] d);
        bus.wr_en = 1'b1; bus.wr_data = d;
        tick(1);
        bus.wr_en = 1'b0; bus.wr_data = 8'h00;
    endtask

    int exp_q [5] = '{1, 1, 1, 0, 1};
    int exp_h [5] = '{0, 1, 0, 0, 1};
    int exp_s [5] = '{1, 2, 3, 4, 0};

    initial begin
        rst = 1'b1; bus.wr_en = 1'b0; bus.wr_data = 8'h00; bus.irq_ack = 1'b0;
        tick(3);
        chk_out("reset", 0, 0, 0);
        chk("reset_irq", int'(bus.frame_irq), 0);
        rst = 1'b0;

        // 4-step frame after reset release
        tick(4); chk_out("m0_s0", 1, 0, 1);
        tick(1); chk("m0_gap_qtr", int'(bus.qtr_clk), 0);
        tick(3); chk_out("m0_s1", 1, 1, 2);
        tick(4); chk_out("m0_s2", 1, 0, 3);
        tick(4); chk_out("m0_s3", 1, 1, 0);
        chk("m0_irq_set", int'(bus.frame_irq), int'(IRQ_EN));

        // Ack alone clears the flag
        tick(1); bus.irq_ack = 1'b1; tick(1); bus.irq_ack = 1'b0;
        chk("ack_alone", int'(bus.frame_irq), 0);

        // Ack on the step-3 completion edge loses to the set
        tick(13); bus.irq_ack = 1'b1; tick(1); bus.irq_ack = 1'b0;
        chk("ack_vs_set", int'(bus.frame_irq), int'(IRQ_EN));
        chk_out("ack_vs_set", 1, 1, 0);
        bus.irq_ack = 1'b1; tick(1); bus.irq_ack = 1'b0;
        chk("ack_later", int'(bus.frame_irq), 0);

        // Inhibiting write clears a pending IRQ and keeps it clear
        tick(15); chk("irq_before_inh", int'(bus.frame_irq), int'(IRQ_EN));
        write(8'h40);
        chk("inh_clear", int'(bus.frame_irq), 0);
        chk_out("inh_write", 0, 0, 0);
        tick(48); chk_out("inh_3frames", 1, 1, 0);
        chk("inh_irq", int'(bus.frame_irq), 0);

        // Write on a step-completion edge suppresses that step's strobe
        tick(3); write(8'h00);
        chk_out("wr_on_step", 0, 0, 0);
        tick(3); chk("wr_gap", int'(bus.qtr_clk), 0);
        tick(1); chk_out("wr_next", 1, 0, 1);

        // 5-step mode with immediate clock
        write(8'h80);
        chk_out("m1_imm", 1, 1, 0);
        for (int k = 0; k < 5; k++) begin
            tick(4);
            chk_out($sformatf("m1_step%0d", k), exp_q[k], exp_h[k], exp_s[k]);
        end
        tick(40); chk("m1_irq", int'(bus.frame_irq), 0);
        chk("m1_wrap_step", int'(bus.step_idx), 0);

        // Asynchronous reset mid-step, then 4-step mode resumes
        tick(10); chk("pre_rst_step", int'(bus.step_idx), 2);
        #2 rst = 1'b1;
        #1 chk_out("async_rst", 0, 0, 0);
        chk("async_rst_irq", int'(bus.frame_irq), 0);
        @(negedge apu_clk); rst = 1'b0;
        tick(3); chk("post_rst_gap", int'(bus.qtr_clk), 0);
        tick(1); chk_out("post_rst_s0", 1, 0, 1);
        tick(12); chk_out("post_rst_s3", 1, 1, 0);
        chk("post_rst_irq", int'(bus.frame_irq), int'(IRQ_EN));
        tick(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
